// File: rtl/bram_scan_pkg.sv
// bram_scan_pkg
//   Shared definitions for the BRAM fill-and-scan display controller:
//   scanner state encoding, the active-low hex glyph table (bit order
//   gfedcba) and the test-pattern generator.
package bram_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_SHOW
    } scan_state_e;

    // Active-low segments, bit order gfedcba, indexed by nibble value.
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Widest word the pattern generator produces; callers cast the result
    // down to their own data width.
    localparam int PAT_MAX_W = 256;

    // Nibble j of word k is (k + j) mod 16. Only k mod 16 matters, so the
    // caller passes just the low four address bits.
    function automatic logic [PAT_MAX_W-1:0] scan_pattern(input logic [3:0] k);
        logic [PAT_MAX_W-1:0] w;
        w = '0;
        for (int j = 0; j < PAT_MAX_W / 4; j++) begin
            w[4*j +: 4] = k + 4'(j);
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
//   Combinational nibble to seven-segment decoder, active-low, gfedcba.
//   nibble_i : 4-bit value to display
//   seg_o    : segment drive, 0 = segment lit
module hex_to_seg7
    import bram_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_GLYPH[nibble_i];

endmodule

// File: rtl/bram_hex_scanner.sv
// bram_hex_scanner
//   Writes a deterministic pattern into the first DEPTH words of a
//   registered BRAM, then reads them back one at a time, showing the low
//   DIGITS hex nibbles of the current word and flagging any readback
//   mismatch. Words advance after DWELL cycles (auto) or on step (manual).
//
//   State table
//     ST_IDLE    | waiting for start, memory port idle, display held
//     ST_FILL    | writing pattern word fill_idx_q
//     ST_RD_ADDR | read address scan_idx_q presented to the BRAM
//     ST_RD_WAIT | BRAM data returning, captured at the closing edge
//     ST_SHOW    | word displayed, waiting for dwell expiry or step
//
//   Ports
//     clk, reset         : clock, async active-low reset
//     start, stop        : begin fill+scan from idle / return to idle
//     auto_mode, step    : advance policy and manual advance
//     mem_addr/_wdata/_we: BRAM port A request (registered)
//     mem_rdata          : BRAM port A read data, one-cycle latency
//     seg                : DIGITS x 7 active-low segment drive
//     cur_addr           : address of the displayed word
//     busy, mismatch     : not idle / sticky readback error
module bram_hex_scanner
    import bram_scan_pkg::*;
#(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16,
    parameter int DIGITS = 6,
    parameter int DWELL  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_mode,
    input  logic                  step,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [7*DIGITS-1:0]   seg,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic                  busy,
    output logic                  mismatch
);

    localparam int                CNT_W    = $clog2(DWELL + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DWELL_TC = CNT_W'(DWELL - 1);

    scan_state_e           state_q;
    logic [ADDR_W-1:0]     fill_idx_q;
    logic [ADDR_W-1:0]     scan_idx_q;
    logic [CNT_W-1:0]      dwell_cnt_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic                  mem_we_q;
    logic [4*DIGITS-1:0]   disp_q;
    logic                  disp_vld_q;
    logic [ADDR_W-1:0]     cur_addr_q;
    logic                  busy_q;
    logic                  mismatch_q;

    logic [ADDR_W-1:0]     fill_idx_d;
    logic [ADDR_W-1:0]     scan_idx_d;
    logic [DATA_W-1:0]     fill_pat_d;
    logic [DATA_W-1:0]     scan_pat;
    logic                  advance;
    logic [7*DIGITS-1:0]   seg_dec;

    assign fill_idx_d = fill_idx_q + 1'b1;
    assign scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
    assign fill_pat_d = DATA_W'(scan_pattern(4'(fill_idx_d)));
    assign scan_pat   = DATA_W'(scan_pattern(4'(scan_idx_q)));
    // Manual mode leaves the dwell counter frozen so switching back to auto
    // resumes the current word's dwell rather than restarting it.
    assign advance    = auto_mode ? (dwell_cnt_q == DWELL_TC) : step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fill_idx_q  <= '0;
            scan_idx_q  <= '0;
            dwell_cnt_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            disp_q      <= '0;
            disp_vld_q  <= 1'b0;
            cur_addr_q  <= '0;
            busy_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else if (state_q != ST_IDLE && stop) begin
            state_q  <= ST_IDLE;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_we_q <= 1'b0;
                    if (start) begin
                        state_q     <= ST_FILL;
                        fill_idx_q  <= '0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= DATA_W'(scan_pattern(4'd0));
                        mem_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        mismatch_q  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (fill_idx_q == LAST_IDX) begin
                        state_q    <= ST_RD_ADDR;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        scan_idx_q <= '0;
                    end else begin
                        fill_idx_q  <= fill_idx_d;
                        mem_addr_q  <= fill_idx_d;
                        mem_wdata_q <= fill_pat_d;
                    end
                end
                ST_RD_ADDR: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    disp_q      <= mem_rdata[4*DIGITS-1:0];
                    disp_vld_q  <= 1'b1;
                    cur_addr_q  <= scan_idx_q;
                    dwell_cnt_q <= '0;
                    if (mem_rdata != scan_pat) begin
                        mismatch_q <= 1'b1;
                    end
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (advance) begin
                        scan_idx_q <= scan_idx_d;
                        mem_addr_q <= scan_idx_d;
                        state_q    <= ST_RD_ADDR;
                    end else if (auto_mode) begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hex_to_seg7 u_dec (
            .nibble_i (disp_q[4*i +: 4]),
            .seg_o    (seg_dec[7*i +: 7])
        );
    end

    // Nothing captured since reset: keep every segment dark.
    assign seg       = disp_vld_q ? seg_dec : '1;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cur_addr  = cur_addr_q;
    assign busy      = busy_q;
    assign mismatch  = mismatch_q;

endmodule

// File: doc/bram_hex_scanner.md
# bram_hex_scanner

Parametrised fill-and-scan controller for a registered dual-port BRAM, driving a multi-digit seven-segment display. On `start` it writes a deterministic test pattern into the first DEPTH words, then reads words back one at a time. It shows the low DIGITS hex nibbles of the current word and flags any readback mismatch. It sits between the board-level buttons/switches and the `bram` instance, replacing the fixed single-digit read-and-decode datapath.

## Interface
- `DATA_W`, 48: BRAM word width; multiple of 4.
- `ADDR_W`, 10: BRAM address width.
- `DEPTH`, 16: words filled/scanned; 1 ≤ DEPTH ≤ 2^ADDR_W.
- `DIGITS`, 6: hex digits displayed; DIGITS*4 ≤ DATA_W.
- `DWELL`, 50_000_000: cycles each word is held in auto mode; ≥ 1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `start` in 1: level-sampled; in IDLE begins fill + scan.
- `stop` in 1: returns to IDLE; display is held.
- `auto_mode` in 1: 1 = advance after DWELL cycles; 0 = advance on `step`.
- `step` in 1: advance one word (manual mode, SHOW only).
- `mem_addr` out ADDR_W: BRAM port A address.
- `mem_wdata` out DATA_W: BRAM port A write data.
- `mem_we` out 1: BRAM port A write enable.
- `mem_rdata` in DATA_W: BRAM port A read data; 1-cycle registered latency.
- `seg` out 7*DIGITS: digit i in bits [7i+6:7i] shows nibble i. Active-low, bit order gfedcba.
- `cur_addr` out ADDR_W: address of the word currently displayed.
- `busy` out 1: state ≠ IDLE.
- `mismatch` out 1: sticky readback error.

## Operation
- Pattern: nibble j of word k = (k + j) mod 16, for j = 0..DATA_W/4−1.
- States: IDLE, FILL, RD_ADDR, RD_WAIT, SHOW.
- IDLE: `mem_we`=0. On `start`=1 → FILL, with fill index=0, `mismatch` cleared.
- FILL: `mem_we`=1, `mem_addr`=index, `mem_wdata`=pattern(index).
  - Index increments each cycle.
  - After the write to DEPTH−1 → RD_ADDR with scan index k=0.
- RD_ADDR: `mem_we`=0, `mem_addr`=k → RD_WAIT.
- RD_WAIT: at the closing edge, `mem_rdata` is captured into the display register and `cur_addr`←k.
  - If `mem_rdata` ≠ pattern(k), `mismatch`←1.
  - → SHOW, with dwell counter cleared.
- SHOW, auto mode: the counter increments each cycle. When it reaches DWELL−1, k←(k+1) and → RD_ADDR.
- SHOW, manual mode: `step`=1 does the same; counter ignored.
- Wrap: k = DEPTH−1 advances to 0. The scan runs indefinitely.
- `stop`=1 in any non-IDLE state → IDLE.
  - Has priority over `step`/dwell expiry.
  - A `stop` during FILL leaves the memory partially written.
- `start` while busy is ignored. `step` outside SHOW is ignored; it is not queued.
- Toggling `auto_mode` in SHOW takes effect next cycle; the dwell counter is not reset.
- Decode: values 0–F use the standard hex glyphs, active-low (e.g. 0 → 7'b1000000, F → 7'b0001110). The display register, not raw `mem_rdata`, drives `seg`.

## Timing
- Reset values:
  - state IDLE; `mem_addr`, `mem_wdata`, `mem_we`, `cur_addr`, `busy`, `mismatch` = 0.
  - Display register blank: `seg` all ones (all segments off).
- `busy` rises the cycle after `start` is sampled.
- First word visible on `seg` DEPTH+2 cycles after the `start` sampling edge.
- Auto mode: each word is held DWELL cycles in SHOW. The period per word is DWELL+2 cycles.
- Manual: new word visible 2 cycles after the `step` sampling edge.
- Async reset mid-FILL/scan: immediate return to reset values. Memory contents are untouched.
- Dwell counter width $clog2(DWELL+1).

## Structure
- Package `bram_scan_pkg` contains:
  - the state enum;
  - the 16-entry seven-segment glyph constant array;
  - the function `scan_pattern(k)`, which returns a DATA_W word.
- Sub-module `hex_to_seg7`: combinational nibble→7-bit active-low decoder, instantiated DIGITS times via generate.
- FSM, counters and compare live in the top module.

## Test plan
- Reset low then high, no start → `seg` all ones, `busy`=0, `mem_we`=0 for 100 cycles.
- DEPTH=16, DWELL=4, auto, `start` pulse → 16 writes, addr 0..15. Word 0 is 0x…543210, so digits 0..5 show 0..5; `seg` digit0=7'b1000000. `cur_addr` steps 0,1,…,15,0 every 6 cycles; `mismatch`=0.
- Manual mode, 3 `step` pulses spaced 10 cycles → `cur_addr` 1,2,3. Each new word is visible 2 cycles after its step. A step during RD_WAIT is ignored.
- Memory model corrupts word 5 → `mismatch` rises on capture of k=5 and stays 1 through wrap. The next `start` from IDLE clears it.
- `stop` asserted mid-FILL at index 7 → IDLE next cycle, `mem_we`=0, `busy`=0. A `stop` and `step` in the same SHOW cycle → IDLE, `cur_addr` unchanged.
- Async reset asserted during SHOW between clock edges → outputs at reset values before the next edge.
